// File: rtl/idct_pkg.sv
// Shared constants and types for the IDCT coefficient stream.
// Block lengths, mode encoding and read-FSM state encoding.
package idct_pkg;

  localparam int W_COEF = 25;

  localparam logic MODE_4X4 = 1'b0;
  localparam logic MODE_8X8 = 1'b1;

  localparam int LEN_4X4 = 16;
  localparam int LEN_8X8 = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP
  } rd_state_t;

endpackage

// File: rtl/idct_coef_bank.sv
// Ping-pong coefficient storage: 2 x 64 words, one write port,
// one asynchronous read port, contents never reset.
module idct_coef_bank
  import idct_pkg::*;
#(
  parameter int W = W_COEF
) (
  input  logic         clk,
  input  logic         we,
  input  logic         wbank,
  input  logic [5:0]   waddr,
  input  logic [W-1:0] wdata,
  input  logic         rbank,
  input  logic [5:0]   raddr,
  output logic [W-1:0] rdata
);

  logic [W-1:0] mem [2][64];

  always_ff @(posedge clk) begin
    if (we) mem[wbank][waddr] <= wdata;
  end

  assign rdata = mem[rbank][raddr];

endmodule

// File: rtl/idct_coef_tx.sv
// Serial coefficient transmitter: commits 4x4/8x8 blocks into
// a ping-pong buffer and streams them one word per cycle.
module idct_coef_tx
  import idct_pkg::*;
#(
  parameter int W   = W_COEF,
  parameter int GAP = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [5:0]   wr_addr,
  input  logic [W-1:0] wr_data,
  input  logic         commit,
  input  logic         commit_mode,
  output logic         commit_ready,
  output logic [W-1:0] seq_out,
  output logic         seq_mode,
  output logic         seq_valid,
  output logic         seq_first,
  output logic         seq_last,
  output logic         busy
);

  localparam logic [2:0] GAP_M1 =
    (GAP > 0) ? 3'(GAP - 1) : 3'd0;
  localparam logic [5:0] LAST_4X4 = 6'(LEN_4X4 - 1);
  localparam logic [5:0] LAST_8X8 = 6'(LEN_8X8 - 1);

  logic [1:0]   full;
  logic [1:0]   bmode;
  logic         wb;
  logic         rb;
  logic [5:0]   cnt;
  logic [2:0]   gcnt;
  rd_state_t    state;
  logic [W-1:0] rd_data;
  logic         wr_ok;
  logic         cm_ok;
  logic         go;
  logic         cur_mode;
  logic         is_last;

  assign commit_ready = ~full[wb];
  assign wr_ok = wr_en & commit_ready;
  assign cm_ok = commit & commit_ready;
  assign busy  = (|full) || (state != ST_IDLE);

  // A word is registered in every SEND cycle and on the IDLE
  // cycle that launches a block, giving commit-to-data of 2.
  assign go = (state == ST_SEND) ||
              ((state == ST_IDLE) && full[rb]);
  assign cur_mode = bmode[rb];
  assign is_last  = cnt == ((cur_mode == MODE_8X8) ?
                            LAST_8X8 : LAST_4X4);

  idct_coef_bank #(.W(W)) u_bank (
    .clk   (clk),
    .we    (wr_ok),
    .wbank (wb),
    .waddr (wr_addr),
    .wdata (wr_data),
    .rbank (rb),
    .raddr (cnt),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full      <= '0;
      bmode     <= '0;
      wb        <= 1'b0;
      rb        <= 1'b0;
      cnt       <= '0;
      gcnt      <= '0;
      state     <= ST_IDLE;
      seq_out   <= '0;
      seq_mode  <= 1'b0;
      seq_valid <= 1'b0;
      seq_first <= 1'b0;
      seq_last  <= 1'b0;
    end else begin
      if (cm_ok) begin
        full[wb]  <= 1'b1;
        bmode[wb] <= commit_mode;
        wb        <= ~wb;
      end
      if (go) begin
        seq_out   <= rd_data;
        seq_valid <= 1'b1;
        seq_first <= (cnt == 6'd0);
        seq_last  <= is_last;
        seq_mode  <= cur_mode;
        if (is_last) begin
          full[rb] <= 1'b0;
          rb       <= ~rb;
          cnt      <= '0;
          if (GAP > 0) begin
            state <= ST_GAP;
            gcnt  <= GAP_M1;
          end else if (full[~rb]) begin
            state <= ST_SEND;
          end else begin
            state <= ST_IDLE;
          end
        end else begin
          cnt   <= cnt + 6'd1;
          state <= ST_SEND;
        end
      end else begin
        seq_out   <= '0;
        seq_valid <= 1'b0;
        seq_first <= 1'b0;
        seq_last  <= 1'b0;
        if (state == ST_GAP) begin
          if (gcnt == 3'd0) state <= ST_IDLE;
          else gcnt <= gcnt - 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_idct_coef_tx.sv
// Directed bench for idct_coef_tx: GAP=1 and GAP=0 instances
// share stimulus; words are captured on the falling edge.
module tb_idct_coef_tx;

  localparam int W = 25;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         wr_en = 1'b0;
  logic [5:0]   wr_addr = '0;
  logic [W-1:0] wr_data = '0;
  logic         commit = 1'b0;
  logic         commit_mode = 1'b0;

  logic         cr1, v1, m1, f1, l1, b1;
  logic [W-1:0] o1;
  logic         cr0, v0, m0, f0, l0, b0;
  logic [W-1:0] o0;

  int cyc = 0;
  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  idct_coef_tx #(.W(W), .GAP(1)) u1 (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .commit_mode(commit_mode),
    .commit_ready(cr1), .seq_out(o1), .seq_mode(m1),
    .seq_valid(v1), .seq_first(f1), .seq_last(l1),
    .busy(b1)
  );

  idct_coef_tx #(.W(W), .GAP(0)) u0 (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .commit_mode(commit_mode),
    .commit_ready(cr0), .seq_out(o0), .seq_mode(m0),
    .seq_valid(v0), .seq_first(f0), .seq_last(l0),
    .busy(b0)
  );

  typedef struct {
    int                 cyc;
    logic signed [W-1:0] d;
    logic               f;
    logic               l;
    logic               m;
  } word_t;

  word_t q1[$];
  word_t q0[$];
  bit    crh [0:8191];

  task automatic chk(string nm, longint act, longint exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (v1) q1.push_back('{cyc, o1, f1, l1, m1});
    if (v0) q0.push_back('{cyc, o0, f0, l0, m0});
    if (cyc < 8192) crh[cyc] = cr1;
    if (reset && !v1)
      chk("idle_outputs_zero",
          longint'({o1 != '0, f1, l1}), 0);
  end

  task automatic drive(input logic we, input int a,
                       input int d, input logic cm,
                       input logic md);
    @(posedge clk);
    #1;
    wr_en       = we;
    wr_addr     = 6'(a);
    wr_data     = W'(d);
    commit      = cm;
    commit_mode = md;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset  = 1'b0;
    wr_en  = 1'b0;
    commit = 1'b0;
    idle(2);
    reset = 1'b1;
    q1.delete();
    q0.delete();
  endtask

  task automatic wait_words(input int n);
    for (int k = 0; k < 300 && q1.size() < n; k++)
      @(posedge clk);
    if (q1.size() < n) begin
      ncmp++;
      nerr++;
      $display("FAIL timeout: got %0d words want %0d",
               q1.size(), n);
    end
  endtask

  task automatic check_block(string nm, input word_t q[$],
                             int off, int start, int md,
                             int len, int base, int step,
                             int ovr_en, int ovr);
    int e;
    for (int i = 0; i < len; i++) begin
      e = (ovr_en != 0 && i == len - 1) ? ovr
                                         : base + step * i;
      if (off + i >= q.size()) begin
        chk({nm, "_missing"}, q.size(), off + len);
        break;
      end
      chk({nm, "_cyc"}, q[off+i].cyc, start + i);
      chk({nm, "_data"}, longint'(q[off+i].d), e);
      chk({nm, "_first"}, q[off+i].f, (i == 0));
      chk({nm, "_last"}, q[off+i].l, (i == len - 1));
      chk({nm, "_mode"}, q[off+i].m, md);
    end
  endtask

  typedef struct {
    string nm;
    int    mode;
    int    nwr;
    int    base;
    int    step;
    int    ovr_en;
    int    ovr;
    int    same;
    int    exp_len;
  } vec_t;

  function automatic int vval(vec_t v, int a);
    if (v.ovr_en != 0 && a == v.exp_len - 1) return v.ovr;
    return v.base + v.step * a;
  endfunction

  initial begin
    vec_t vt[4];
    int c;

    vt[0] = '{"blk4x4", 0, 16, 100, 1, 0, 0, 0, 16};
    vt[1] = '{"blk8x8neg", 1, 64, -1, -1, 1, -16777216, 0, 64};
    vt[2] = '{"samecyc", 0, 16, 400, 1, 1, 7, 1, 16};
    vt[3] = '{"m0hi", 0, 64, -16777216, 1, 1, 16777215, 0, 16};

    reset = 1'b0;
    idle(3);
    chk("rst_valid", v1, 0);
    chk("rst_out", longint'(o1), 0);
    chk("rst_mode", m1, 0);
    chk("rst_ready", cr1, 1);
    chk("rst_busy", b1, 0);
    reset = 1'b1;

    foreach (vt[t]) begin
      do_reset();
      for (int a = 0; a < vt[t].nwr; a++)
        drive(1, a, vval(vt[t], a),
              (vt[t].same != 0) && (a == vt[t].nwr - 1),
              1'(vt[t].mode));
      if (vt[t].same == 0) drive(0, 0, 0, 1, 1'(vt[t].mode));
      c = cyc;
      idle(1);
      wait_words(vt[t].exp_len);
      idle(10);
      check_block(vt[t].nm, q1, 0, c + 2, vt[t].mode,
                  vt[t].exp_len, vt[t].base, vt[t].step,
                  vt[t].ovr_en, vt[t].ovr);
      chk({vt[t].nm, "_count"}, q1.size(), vt[t].exp_len);
      chk({vt[t].nm, "_busy"}, b1, 0);
    end

    // Preload both banks, then reset: contents survive.
    do_reset();
    for (int a = 0; a < 16; a++) drive(1, a, 200 + a, 0, 0);
    drive(0, 0, 0, 1, 0);
    for (int a = 0; a < 64; a++) drive(1, a, 300 + a, 0, 0);
    drive(0, 0, 0, 1, 1);
    idle(100);
    do_reset();
    drive(0, 0, 0, 1, 0);
    c = cyc;
    drive(0, 0, 0, 1, 1);
    drive(0, 0, 0, 1, 0);
    idle(1);
    wait_words(80);
    idle(20);
    check_block("pingA", q1, 0, c + 2, 0, 16, 200, 1, 0, 0);
    check_block("pingB", q1, 16, c + 19, 1, 64, 300, 1, 0, 0);
    chk("ping_count", q1.size(), 80);
    chk("ping_ready_full", crh[c+2], 0);
    chk("ping_ready_pre", crh[c+16], 0);
    chk("ping_ready_free", crh[c+17], 1);
    check_block("gap0A", q0, 0, c + 2, 0, 16, 200, 1, 0, 0);
    check_block("gap0B", q0, 16, c + 18, 1, 64, 300, 1, 0, 0);
    chk("gap0_count", q0.size(), 80);
    chk("ping_busy", b1, 0);

    // Asynchronous reset while word 10 is on the output.
    do_reset();
    for (int a = 0; a < 64; a++) drive(1, a, 500 + a, 0, 0);
    drive(0, 0, 0, 1, 1);
    idle(12);
    chk("abort_w10_valid", v1, 1);
    chk("abort_w10_data", longint'(o1), 510);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_valid", v1, 0);
    chk("abort_out", longint'(o1), 0);
    chk("abort_ready", cr1, 1);
    chk("abort_words", q1.size(), 10);
    idle(2);
    reset = 1'b1;
    q1.delete();
    idle(100);
    chk("abort_quiet", q1.size(), 0);
    chk("abort_ready2", cr1, 1);
    chk("abort_busy", b1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
